pht_branch_predictor: RTL and testbench

//   PC-indexed pattern history table: 2**IDX_BITS independent CTR_BITS-wide saturating

---
 rtl/pht_branch_predictor_pkg.sv | 27 ++
 rtl/pht_branch_predictor_sat_counter_update.sv | 31 +++
 rtl/pht_branch_predictor.sv | 80 ++++++++
 tb/tb_pht_branch_predictor.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pht_branch_predictor_pkg.sv
// Shared opcode constants and predictor sizing helpers for the pattern history table.
package pht_branch_predictor_pkg;

    localparam logic [11:0] OPC_ADD = 12'h001;
    localparam logic [11:0] OPC_BEQ = 12'h010;
    localparam logic [11:0] OPC_BNE = 12'h011;

    localparam int DEF_CTR_BITS = 3;
    localparam int DEF_IDX_BITS = 4;

    function automatic int half_of(input int ctr_bits);
        return 1 << (ctr_bits - 1);
    endfunction

    function automatic int ctr_max_of(input int ctr_bits);
        return (1 << ctr_bits) - 1;
    endfunction

    function automatic int entries_of(input int idx_bits);
        return 1 << idx_bits;
    endfunction

    function automatic logic is_br(input logic [11:0] opc);
        return (opc == OPC_BEQ) || (opc == OPC_BNE);
    endfunction

endpackage

// File: rtl/pht_branch_predictor_sat_counter_update.sv
// Next-value logic for one saturating branch counter; width-generic so other tables can reuse it.
module sat_counter_update
    import pht_branch_predictor_pkg::*;
#(
    parameter int CTR_BITS = DEF_CTR_BITS
) (
    input  logic [CTR_BITS-1:0] ctr,
    input  logic                wrong,
    output logic [CTR_BITS-1:0] next_ctr
);

    localparam logic [CTR_BITS-1:0] HALF    = CTR_BITS'(half_of(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_MAX = CTR_BITS'(ctr_max_of(CTR_BITS));
    localparam logic [CTR_BITS-1:0] ONE     = CTR_BITS'(1);

    logic taken_side;
    assign taken_side = (ctr >= HALF);

    // A mispredict steps toward the opposite side; a hit strengthens, clamped at both ends.
    always_comb begin
        next_ctr = ctr;
        if (wrong) begin
            next_ctr = taken_side ? (ctr - ONE) : (ctr + ONE);
        end else if (taken_side) begin
            if (ctr != CTR_MAX) next_ctr = ctr + ONE;
        end else begin
            if (ctr != '0) next_ctr = ctr - ONE;
        end
    end

endmodule

// File: rtl/pht_branch_predictor.sv
// PC-indexed table of saturating counters: decode lookup, commit-time training.
// Optional gshare history indexing when GSHARE_PREDICTOR_EN is defined.
module pht_branch_predictor
    import pht_branch_predictor_pkg::*;
#(
    parameter int CTR_BITS = DEF_CTR_BITS,
    parameter int IDX_BITS = DEF_IDX_BITS,
    parameter int INIT_CTR = (1 << CTR_BITS) - 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         PC,
    input  logic [11:0]         Decoded_opcode,
    input  logic [31:0]         Commit_PC,
    input  logic [11:0]         Commit_opcode,
    input  logic                Wrong_prediction,
    output logic                predicted,
    output logic [IDX_BITS-1:0] Predict_index
);

    localparam int HALF    = half_of(CTR_BITS);
    localparam int ENTRIES = entries_of(IDX_BITS);

    logic [CTR_BITS-1:0] ctr_q [ENTRIES];
    logic [IDX_BITS-1:0] hist;
    logic [IDX_BITS-1:0] pred_idx;
    logic [IDX_BITS-1:0] commit_idx;
    logic [CTR_BITS-1:0] ctr_pre;
    logic [CTR_BITS-1:0] ctr_next;
    logic                commit_br;

`ifdef GSHARE_PREDICTOR_EN
    logic [IDX_BITS-1:0] ghr_q;
    logic                taken;

    // History records the resolved direction, so it never needs rollback.
    assign taken = (ctr_pre >= CTR_BITS'(HALF)) ^ Wrong_prediction;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr_q <= '0;
        end else if (commit_br) begin
            ghr_q <= (ghr_q << 1) | IDX_BITS'(taken);
        end
    end

    assign hist = ghr_q;
`else
    assign hist = '0;
`endif

    assign pred_idx   = PC[IDX_BITS+1:2] ^ hist;
    assign commit_idx = Commit_PC[IDX_BITS+1:2] ^ hist;
    assign ctr_pre    = ctr_q[commit_idx];
    assign commit_br  = is_br(Commit_opcode);

    sat_counter_update #(.CTR_BITS(CTR_BITS)) u_update (
        .ctr      (ctr_pre),
        .wrong    (Wrong_prediction),
        .next_ctr (ctr_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_BITS'(INIT_CTR);
            end
        end else if (commit_br) begin
            ctr_q[commit_idx] <= ctr_next;
        end
    end

    // Lookup reads the registered table, so a same-cycle commit is seen one cycle later.
    assign predicted     = rst & is_br(Decoded_opcode) & (ctr_q[pred_idx] >= CTR_BITS'(HALF));
    assign Predict_index = pred_idx;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{PC[31:IDX_BITS+2], PC[1:0], Commit_PC[31:IDX_BITS+2], Commit_PC[1:0]};

endmodule

// File: tb/tb_pht_branch_predictor.sv
// Bench for pht_branch_predictor: directed literal checks plus randomized traffic
// against an integer table model. Honours GSHARE_PREDICTOR_EN.
module tb_pht_branch_predictor;
  import pht_branch_predictor_pkg::*;

  localparam int HALF = 4;
  localparam int CMAX = 7;
  localparam int NENT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] PC = '0;
  logic [11:0] Decoded_opcode = OPC_ADD;
  logic [31:0] Commit_PC = '0;
  logic [11:0] Commit_opcode = OPC_ADD;
  logic        Wrong_prediction = 1'b0;
  logic        predicted;
  logic [3:0]  Predict_index;

  int n_cmp = 0;
  int n_bad = 0;

  int m_ctr [NENT];
  int m_ghr = 0;

  pht_branch_predictor #(.CTR_BITS(3), .IDX_BITS(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .PC               (PC),
    .Decoded_opcode   (Decoded_opcode),
    .Commit_PC        (Commit_PC),
    .Commit_opcode    (Commit_opcode),
    .Wrong_prediction (Wrong_prediction),
    .predicted        (predicted),
    .Predict_index    (Predict_index)
  );

  // clock
  always #5 clk = ~clk;

  function automatic bit m_is_br(input logic [11:0] opc);
    return (opc == OPC_BEQ) || (opc == OPC_BNE);
  endfunction

  function automatic int m_idx(input logic [31:0] pc);
    int base;
    base = int'((pc >> 2) & 32'hF);
`ifdef GSHARE_PREDICTOR_EN
    return base ^ m_ghr;
`else
    return base;
`endif
  endfunction

  // reference model: async reset clears, commits of branches train one entry
  always @(posedge clk or negedge rst) begin
    int e;
    int pre;
    int tk;
    if (!rst) begin
      for (int i = 0; i < NENT; i++) m_ctr[i] = CMAX;
      m_ghr = 0;
    end else if (m_is_br(Commit_opcode)) begin
      e   = m_idx(Commit_PC);
      pre = m_ctr[e];
      if (Wrong_prediction) begin
        m_ctr[e] = (pre >= HALF) ? pre - 1 : pre + 1;
      end else if (pre >= HALF) begin
        m_ctr[e] = (pre + 1 > CMAX) ? CMAX : pre + 1;
      end else begin
        m_ctr[e] = (pre - 1 < 0) ? 0 : pre - 1;
      end
      tk = ((pre >= HALF) ? 1 : 0) ^ (Wrong_prediction ? 1 : 0);
      m_ghr = ((m_ghr * 2) + tk) % NENT;
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    logic       exp_pred;
    logic [3:0] exp_idx;
    exp_idx  = 4'(m_idx(PC));
    exp_pred = rst && m_is_br(Decoded_opcode) && (m_ctr[m_idx(PC)] >= HALF);
    n_cmp++;
    if (predicted !== exp_pred) begin
      n_bad++;
      $display("FAIL model_predicted t=%0t pc=%h got %b expected %b", $time, PC, predicted, exp_pred);
    end
    n_cmp++;
    if (Predict_index !== exp_idx) begin
      n_bad++;
      $display("FAIL model_index t=%0t pc=%h got %0d expected %0d", $time, PC, Predict_index, exp_idx);
    end
  end

  // driver tasks
  task automatic set_in(input logic [31:0] dpc, input logic [11:0] dop,
                        input logic [31:0] cpc, input logic [11:0] cop, input logic wr);
    PC = dpc;
    Decoded_opcode = dop;
    Commit_PC = cpc;
    Commit_opcode = cop;
    Wrong_prediction = wr;
  endtask

  task automatic lit(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Called at posedge+1: apply inputs, check predicted mid-cycle, advance to next posedge+1.
  task automatic step(input logic [31:0] dpc, input logic [11:0] dop,
                      input logic [31:0] cpc, input logic [11:0] cop, input logic wr,
                      input string name, input int exp_pred);
    set_in(dpc, dop, cpc, cop, wr);
    @(negedge clk);
    lit(name, int'(predicted), exp_pred);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] opc_tab [4];
    opc_tab[0] = OPC_BEQ;
    opc_tab[1] = OPC_BNE;
    opc_tab[2] = OPC_ADD;
    opc_tab[3] = 12'h3A5;

    rst = 1'b0;
    set_in(32'h40, OPC_BEQ, 32'h0, OPC_ADD, 1'b0);
    @(negedge clk);
    lit("pred_in_reset", int'(predicted), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // every entry comes out of reset strongly taken
    for (int i = 0; i < NENT; i++) step(32'(i * 4), OPC_BEQ, 32'h0, OPC_ADD, 1'b0, "reset_entry", 1);

    // mispredict walk 7->6->5->4->3
    for (int k = 0; k < 4; k++) step(32'h40, OPC_BEQ, 32'h40, OPC_BEQ, 1'b1, "mispredict_walk", 1);
    step(32'h40, OPC_BNE, 32'h0, OPC_ADD, 1'b0, "walk_flipped", 0);

    // correct commits 3->2->1->0->0
    for (int k = 0; k < 4; k++) step(32'h40, OPC_BEQ, 32'h40, OPC_BEQ, 1'b0, "correct_walk", 0);

    // aliasing and isolation
    step(32'h44, OPC_BEQ, 32'h0, OPC_ADD, 1'b0, "alias_neighbour", 1);
    step(32'h80, OPC_BNE, 32'h0, OPC_ADD, 1'b0, "alias_same_idx", 0);

`ifndef GSHARE_PREDICTOR_EN
    // from 0, three mispredicts stay below half: proves no wrap at 0
    for (int k = 0; k < 3; k++) step(32'h80, OPC_BEQ, 32'h40, OPC_BEQ, 1'b1, "sat_low_walk", 0);
    step(32'h80, OPC_BEQ, 32'h40, OPC_BEQ, 1'b1, "sat_low_last", 0);
    // ctr=4 now: same-cycle read sees pre-edge value
    step(32'h40, OPC_BEQ, 32'h40, OPC_BEQ, 1'b1, "hazard_same_cycle", 1);
    step(32'h40, OPC_BEQ, 32'h0, OPC_ADD, 1'b0, "hazard_next", 0);
    // saturation at 7: hold, then 7->6->5->4 still taken
    step(32'h48, OPC_BEQ, 32'h48, OPC_BEQ, 1'b0, "sat_high_hold", 1);
    for (int k = 0; k < 3; k++) step(32'h48, OPC_BEQ, 32'h48, OPC_BEQ, 1'b1, "sat_high_walk", 1);
    step(32'h48, OPC_BEQ, 32'h0, OPC_ADD, 1'b0, "sat_high_after", 1);
`endif

    // non-branch decode and commit
    step(32'h40, OPC_ADD, 32'h40, OPC_ADD, 1'b1, "decode_nonbranch", 0);
    step(32'h40, OPC_BEQ, 32'h40, OPC_ADD, 1'b1, "nonbranch_no_write", 0);

    // asynchronous reset mid-cycle; the coinciding commit is dropped
    set_in(32'h40, OPC_BEQ, 32'h40, OPC_BEQ, 1'b1);
    #2;
    rst = 1'b0;
    @(negedge clk);
    lit("pred_during_reset", int'(predicted), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(32'h40, OPC_BEQ, 32'h0, OPC_ADD, 1'b0, "pred_after_reset", 1);

    // two taken commits; in gshare mode history becomes 4'b0011
    step(32'h44, OPC_BEQ, 32'h44, OPC_BEQ, 1'b0, "ghr_commit_a", 1);
    step(32'h44, OPC_BEQ, 32'h44, OPC_BEQ, 1'b0, "ghr_commit_b", 1);
    set_in(32'h40, OPC_BEQ, 32'h0, OPC_ADD, 1'b0);
    @(negedge clk);
`ifdef GSHARE_PREDICTOR_EN
    lit("gshare_index", int'(Predict_index), 3);
`else
    lit("bimodal_index", int'(Predict_index), 0);
`endif
    @(posedge clk);
    #1;

    // randomized traffic, with occasional asynchronous reset pulses
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] dpc;
      logic [31:0] cpc;
      dpc = ($urandom_range(0, 255) << 2) | 32'($urandom_range(0, 3));
      cpc = ($urandom_range(0, 63) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) cpc = $urandom();
      set_in(dpc, opc_tab[$urandom_range(0, 3)], cpc,
             opc_tab[$urandom_range(0, 3)], 1'($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 299) == 0) begin
        #2;
        rst = 1'b0;
      end else begin
        rst = 1'b1;
      end
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
